mult_share_ctrl: RTL and testbench
==================================

Name: mult_share_ctrl

Overview:
- Sequential shift-add unsigned multiplier shared among NREQ requesters through a round-robin arbiter.
- Each requester presents an operand pair with a valid/ready handshake. The block grants one requester, iterates the shift-add algorithm one multiplier bit per clock, and returns the 2*WIDTH-bit product tagged with the requester ID.
- Sits between the ALU/issue logic and the multiply resource. It replaces per-requester combinational multipliers with one time-shared datapath.

Parameters:
- NREQ, 2, number of requesters (>=2).
- WIDTH, 32, operand width in bits.
- IDW, 1, width of the requester ID; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  NREQ*WIDTH  multiplicands; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  multipliers; same packing as req_a.
- rsp_valid  output  1  product available.
- rsp_ready  input  1  consumer accepts the product.
- rsp_id  output  IDW  index of the requester that owns rsp_product.
- rsp_product  output  2*WIDTH  unsigned product a*b.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous, active-high), applied at any time including mid-operation:
  - state=IDLE, rr_ptr=0, cycle count=0.
  - rsp_valid=0, rsp_id=0, rsp_product=0, busy=0, req_ready=0.
  - Any in-flight operation is discarded; no response is ever issued for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
  - req_ready[grant]=1, combinational from req_valid and state; all other bits are 0. If no request is valid, req_ready=0.
  - At the edge where req_valid[grant]&req_ready[grant]=1:
    - latch a=req_a[grant].
    - product register P={WIDTH'b0, req_b[grant]}.
    - id=grant, count=0.
    - go to RUN.
  - A requester that drops valid before acceptance has no effect.
  - Operands are sampled only at the acceptance edge.
- RUN, per clock:
  - If P[0]=1: {c, P[2W-1:W]} = P[2W-1:W] + a, computed in WIDTH+1 bits; otherwise c=0.
  - Then P = {c, P[2W-1:1]} (shift right with carry in).
  - count increments by 1.
  - After the WIDTH-th RUN cycle, go to DONE.
  - Result is exact: P = a*b with no truncation.
- Latency: rsp_valid rises WIDTH+1 clock edges after the acceptance edge (33 for WIDTH=32).
- DONE:
  - rsp_valid=1; rsp_product=P and rsp_id=id, both held stable while rsp_valid=1.
  - Stay in DONE while rsp_ready=0.
  - At the edge where rsp_ready=1: go to IDLE, rr_ptr=(id+1) mod NREQ, rsp_valid=0.
  - rsp_ready=1 on the first DONE cycle completes in that cycle.
  - No request is accepted in DONE, so there is at least one IDLE cycle between jobs.
- rsp_ready asserted while rsp_valid=0 is ignored.
- All of req_ready is 0 in RUN and DONE.
- Fairness: a continuously requesting requester waits at most NREQ-1 jobs.
- Zero operands still take the full latency (unless MULT_EARLY_TERM_EN is defined).
- Maximum operands: FFFFFFFF*FFFFFFFF=FFFFFFFE00000001; the carry out of the upper-half add must be preserved.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined:
  - In RUN, after each iteration, if the unprocessed multiplier bits P[WIDTH-1-count-1 : 0] (the remaining low bits) are all zero, P is shifted right by the remaining iteration count in one step and the state goes to DONE.
  - Latency becomes (index of the highest set bit of b)+2 edges; b=0 gives 2 edges.
  - Products are identical to the non-early-terminated result.
- Undefined: fixed WIDTH+1 latency, and no early-termination logic is synthesized.

Test Plan:
- Single request, NREQ=2: req0 a=3, b=5 -> req_ready[0] for 1 cycle; rsp_valid 33 edges later; rsp_product=15, rsp_id=0.
- Max operands: a=b=FFFFFFFF -> rsp_product=FFFFFFFE00000001.
- Round-robin: req0 and req1 both held valid for 4 jobs -> grant order 0,1,0,1; each response ID matches its operands (req0 7*9=63, req1 6*11=66).
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid, rsp_product and rsp_id stay stable; req_ready stays 0 throughout; release completes the job and the next grant follows.
- Reset mid-RUN (edge 10 after acceptance) -> all outputs 0 immediately; no response for that job; a new request afterwards gives a correct product.
- MULT_EARLY_TERM_EN defined: b=1, a=1234 -> rsp_valid after 2 edges with product 1234; b=0 -> product 0 after 2 edges; b=80000000 -> product matches the non-early result, latency 33.

Source files
------------

// File: rtl/mult_share_ctrl.sv
// Round-robin shared shift-add multiplier: one multiplier bit per clock, result WIDTH+1 edges from acceptance; DONE holds until rsp_ready.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module mult_share_ctrl #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32,
    parameter int IDW   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_product,
    output logic                  busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_id;
    logic [IDW-1:0]     w_grant;
    logic               w_found;
    logic               w_accept;
    logic               w_last;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_p;
    logic [2*WIDTH-1:0] w_p_step;
    logic [2*WIDTH-1:0] w_p_nxt;
    logic [WIDTH:0]     w_sum;
    int                 v_idx;
`ifdef MULT_EARLY_TERM_EN
    logic [WIDTH-1:0]   w_rem_mask;
`endif

    // Round-robin search starting at r_rr_ptr, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        v_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NREQ) v_idx = v_idx - NREQ;
            if (!w_found && req_valid[v_idx]) begin
                w_found = 1'b1;
                w_grant = IDW'(v_idx);
            end
        end
    end

    // One shift-add step; the sum keeps its carry so the product is exact.
    always_comb begin
        w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
        w_p_step = {w_sum, r_p[WIDTH-1:1]};
        w_p_nxt  = w_p_step;
        w_last   = (r_count == CW'(WIDTH - 1));
`ifdef MULT_EARLY_TERM_EN
        w_rem_mask = {WIDTH{1'b1}} >> (r_count + CW'(1));
        if (!w_last && ((w_p_step[WIDTH-1:0] & w_rem_mask) == '0)) begin
            w_last  = 1'b1;
            w_p_nxt = w_p_step >> (CW'(WIDTH - 1) - r_count);
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !reset) begin
                    req_ready[w_grant] = 1'b1;
                    w_accept           = 1'b1;
                    w_state_nxt        = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_count  <= '0;
            r_a      <= '0;
            r_p      <= '0;
        end else if (w_accept) begin
            r_a     <= req_a[int'(w_grant)*WIDTH +: WIDTH];
            r_p     <= {{WIDTH{1'b0}}, req_b[int'(w_grant)*WIDTH +: WIDTH]};
            r_id    <= w_grant;
            r_count <= '0;
        end else if (r_state == S_RUN) begin
            r_p     <= w_p_nxt;
            r_count <= r_count + CW'(1);
        end else if (r_state == S_DONE && rsp_ready) begin
            r_rr_ptr <= IDW'((int'(r_id) + 1) % NREQ);
        end
    end

    assign rsp_valid   = (r_state == S_DONE);
    assign rsp_id      = (r_state == S_DONE) ? r_id : '0;
    assign rsp_product = (r_state == S_DONE) ? r_p : '0;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl (NREQ=2, WIDTH=32); latencies count the acceptance edge as edge 1.
module tb_mult_share_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [63:0] rsp_product;
    logic        busy;

    int vecs = 0;
    int errs = 0;

    mult_share_ctrl #(.NREQ(2), .WIDTH(32), .IDW(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_product(rsp_product), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
        int h;
        h = 0;
        for (int i = 0; i < 32; i++) if (b[i]) h = i;
        return h + 2;
`else
        return 33;
`endif
    endfunction

    // Called at the negedge after the acceptance edge.
    task automatic wait_rsp(output int edges);
        edges = 1;
        while (!rsp_valid && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_after_release", rsp_valid, 0);
    endtask

    // Single-requester job, entered and left at a negedge.
    task automatic do_job(input string tag, input int id, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] prod);
        int lat;
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_valid[id]      = 1'b1;
        #1 check({tag, "_ready"}, req_ready, 64'(2'b01 << id));
        @(posedge clk);
        @(negedge clk);
        req_valid[id] = 1'b0;
        check({tag, "_busy"}, busy, 1);
        wait_rsp(lat);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat(b)));
        check({tag, "_product"}, rsp_product, prod);
        check({tag, "_id"}, rsp_id, 64'(id));
        release_rsp();
    endtask

    initial begin
        int lat;
        bit seen;
        reset     = 1'b1;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_product", rsp_product, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        req_valid = 2'b00;
        reset     = 1'b0;
        @(negedge clk);

        // rsp_ready while idle must not start anything
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_rsp_ready_ignored", {busy, rsp_valid}, 0);

        do_job("single_3x5", 0, 32'd3, 32'd5, 64'd15);
        do_job("max_ops", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

        // Round robin: both held valid for four jobs, rr_ptr is 0 here
        req_a     = {32'd6, 32'd7};
        req_b     = {32'd11, 32'd9};
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            #1 check("rr_grant", req_ready, (j % 2 == 0) ? 64'd1 : 64'd2);
            @(posedge clk);
            @(negedge clk);
            check("rr_ready_run", req_ready, 0);
            wait_rsp(lat);
            check("rr_latency", 64'(lat), 64'(exp_lat((j % 2 == 0) ? 32'd9 : 32'd11)));
            check("rr_id", rsp_id, 64'(j % 2));
            check("rr_product", rsp_product, (j % 2 == 0) ? 64'd63 : 64'd66);
            release_rsp();
        end
        req_valid = 2'b00;

        // Backpressure: req1 waits while the req0 result is held
        req_a     = {32'd2, 32'h0000_1234};
        req_b     = {32'd3, 32'h0000_0010};
        req_valid = 2'b11;
        #1 check("bp_grant", req_ready, 2'b01);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b10;
        wait_rsp(lat);
        check("bp_product", rsp_product, 64'h12340);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_product", rsp_product, 64'h12340);
            check("bp_hold_id", rsp_id, 0);
            check("bp_hold_ready", req_ready, 0);
        end
        release_rsp();
        check("bp_next_grant", req_ready, 2'b10);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(lat);
        check("bp_next_id", rsp_id, 1);
        check("bp_next_product", rsp_product, 64'd6);
        release_rsp();

        // Reset at edge 10 after acceptance; the job must vanish
        req_a[31:0]  = 32'd100;
        req_b[31:0]  = 32'hFFFF_FFFF;
        req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (9) @(posedge clk);
        #2 check("midrun_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_outputs", {rsp_valid, rsp_id, rsp_product, req_ready}, 0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        check("midrun_no_response", seen, 0);
        do_job("after_reset", 0, 32'h1234_5678, 32'd9, 64'h0000_0000_A3D7_0A38);

        // Early-termination corner operands (fixed latency when the feature is off)
        do_job("b_one", 0, 32'd1234, 32'd1, 64'd1234);
        do_job("b_zero", 1, 32'd5, 32'd0, 64'd0);
        do_job("b_msb", 0, 32'd3, 32'h8000_0000, 64'h1_8000_0000);
        do_job("b_mid", 1, 32'hDEAD_BEEF, 32'h0001_0001, 64'h0000_DEAE_9D9C_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
